// File: rtl/core_pkg.sv
// Shared ALU opcode encodings, width constants and issue-stage state type.
package core_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREG_DEF  = 32;
  localparam int REG_IDX_W = 5;
  localparam int ALU_OP_W  = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_EQ   = 4'd10
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } issue_state_e;

  // Codes above the last defined opcode are flagged but still forwarded.
  function automatic logic op_is_illegal(input logic [ALU_OP_W-1:0] op);
    return op > ALU_OP_W'(ALU_EQ);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass select: x0, then execute-stage result, then writeback, then register file.
module fwd_mux
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RW   = REG_IDX_W
) (
  input  logic [RW-1:0]   rs_i,
  input  logic [XLEN-1:0] rf_data_i,
  input  logic            ex_valid_i,
  input  logic [RW-1:0]   ex_rd_i,
  input  logic [XLEN-1:0] ex_data_i,
  input  logic            ex_is_load_i,
  input  logic            wb_valid_i,
  input  logic [RW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] data_o
);

  // A load in execute has no data yet; the hazard logic stalls instead of bypassing it.
  always_comb begin
    data_o = rf_data_i;
    if (rs_i == '0) begin
      data_o = '0;
    end else if (ex_valid_i && !ex_is_load_i && (ex_rd_i == rs_i)) begin
      data_o = ex_data_i;
    end else if (wb_valid_i && (wb_rd_i == rs_i)) begin
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: operand resolution with bypass, load-use stall, and a one-entry
// registered output slot handshaking with execute.
module alu_issue
  import core_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  localparam int RW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [ALU_OP_W-1:0] dec_alu_op,
  input  logic [RW-1:0]       dec_rs1,
  input  logic [RW-1:0]       dec_rs2,
  input  logic [RW-1:0]       dec_rd,
  input  logic                dec_use_imm,
  input  logic [XLEN-1:0]     dec_imm,
  input  logic [XLEN-1:0]     dec_pc,
  input  logic                dec_src1_pc,
  output logic [RW-1:0]       rf_raddr1,
  output logic [RW-1:0]       rf_raddr2,
  input  logic [XLEN-1:0]     rf_rdata1,
  input  logic [XLEN-1:0]     rf_rdata2,
  input  logic                ex_fwd_valid,
  input  logic [RW-1:0]       ex_fwd_rd,
  input  logic [XLEN-1:0]     ex_fwd_data,
  input  logic                ex_fwd_is_load,
  input  logic                wb_fwd_valid,
  input  logic [RW-1:0]       wb_fwd_rd,
  input  logic [XLEN-1:0]     wb_fwd_data,
  input  logic                flush,
  output logic                alu_valid,
  input  logic                alu_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [XLEN-1:0]     src1,
  output logic [XLEN-1:0]     src2,
  output logic [XLEN-1:0]     pc,
  output logic [RW-1:0]       rd,
  output logic                illegal
);

  issue_state_e        state_q;
  logic [ALU_OP_W-1:0] alu_op_q;
  logic [XLEN-1:0]     src1_q, src2_q, pc_q;
  logic [RW-1:0]       rd_q;
  logic                illegal_q;

  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] src1_d, src2_d;
  logic            illegal_d;
  logic            hazard;
  logic            slot_free;
  logic            accept;

  assign rf_raddr1 = dec_rs1;
  assign rf_raddr2 = dec_rs2;

  fwd_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_rs1 (
    .rs_i        (dec_rs1),
    .rf_data_i   (rf_rdata1),
    .ex_valid_i  (ex_fwd_valid),
    .ex_rd_i     (ex_fwd_rd),
    .ex_data_i   (ex_fwd_data),
    .ex_is_load_i(ex_fwd_is_load),
    .wb_valid_i  (wb_fwd_valid),
    .wb_rd_i     (wb_fwd_rd),
    .wb_data_i   (wb_fwd_data),
    .data_o      (rs1_val)
  );

  fwd_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_rs2 (
    .rs_i        (dec_rs2),
    .rf_data_i   (rf_rdata2),
    .ex_valid_i  (ex_fwd_valid),
    .ex_rd_i     (ex_fwd_rd),
    .ex_data_i   (ex_fwd_data),
    .ex_is_load_i(ex_fwd_is_load),
    .wb_valid_i  (wb_fwd_valid),
    .wb_rd_i     (wb_fwd_rd),
    .wb_data_i   (wb_fwd_data),
    .data_o      (rs2_val)
  );

  assign src1_d    = dec_src1_pc ? dec_pc  : rs1_val;
  assign src2_d    = dec_use_imm ? dec_imm : rs2_val;
  assign illegal_d = op_is_illegal(dec_alu_op);

  // Only sources actually consumed by the instruction can create a load-use stall.
  assign hazard = ex_fwd_valid && ex_fwd_is_load && (ex_fwd_rd != '0) &&
                  ((!dec_src1_pc && (ex_fwd_rd == dec_rs1)) ||
                   (!dec_use_imm && (ex_fwd_rd == dec_rs2)));

  assign slot_free = (state_q == ST_EMPTY) || alu_ready;
  assign dec_ready = slot_free && !hazard && !flush && !rst;
  assign accept    = dec_valid && dec_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      alu_op_q  <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      pc_q      <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else if (accept) begin
      state_q   <= ST_FULL;
      alu_op_q  <= dec_alu_op;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      pc_q      <= dec_pc;
      rd_q      <= dec_rd;
      illegal_q <= illegal_d;
    end else if ((state_q == ST_FULL) && alu_ready) begin
      state_q <= ST_EMPTY;
    end
  end

  assign alu_valid = (state_q == ST_FULL);
  assign alu_op    = alu_op_q;
  assign src1      = src1_q;
  assign src2      = src2_q;
  assign pc        = pc_q;
  assign rd        = rd_q;
  assign illegal   = illegal_q;

endmodule
